// File: rtl/sha_digest_tx.sv
// Captures a 256-bit SHA-256 digest on a done strobe and streams it out as eight words, H0 first.
// Optional SHA_DIGEST_TX_BSWAP_EN byte-reverses each emitted word (Bitcoin little-endian order).
module sha_digest_tx #(
  parameter int WORD_S   = 32,
  parameter int H_BLKCNT = 8,
  parameter int H_SIZE   = WORD_S * H_BLKCNT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [H_SIZE-1:0] H_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_S-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              overrun
);

  localparam int IDX_W = $clog2(H_BLKCNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(H_BLKCNT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             r_state;
  logic [H_SIZE-1:0]  r_buf;
  logic [IDX_W-1:0]   r_idx;
  logic [WORD_S-1:0]  r_data;
  logic               r_valid;
  logic               r_last;
  logic               r_busy;
  logic               r_ovr;

  logic               w_xfer;
  logic               w_final;
  logic               w_capture;
  logic [IDX_W-1:0]   w_idx_nxt;

  function automatic logic [WORD_S-1:0] fmt_word(input logic [H_SIZE-1:0] h,
                                                 input logic [IDX_W-1:0]  k);
    logic [WORD_S-1:0] w;
    fmt_word = '0;
    w = h[int'(k)*WORD_S +: WORD_S];
`ifdef SHA_DIGEST_TX_BSWAP_EN
    for (int b = 0; b < WORD_S/8; b++)
      fmt_word[b*8 +: 8] = w[WORD_S-8-b*8 +: 8];
`else
    fmt_word = w;
`endif
  endfunction

  assign w_xfer    = r_valid & m_ready;
  assign w_final   = w_xfer && (r_idx == '0);
  // A strobe landing on the final handshake chains the next digest with no bubble.
  assign w_capture = en_i && ((r_state == IDLE) || w_final);
  assign w_idx_nxt = r_idx - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_state <= SEND;
        r_buf   <= H_i;
        r_idx   <= LAST_IDX;
        r_data  <= fmt_word(H_i, LAST_IDX);
        r_valid <= 1'b1;
        r_last  <= (LAST_IDX == '0);
        r_busy  <= 1'b1;
      end else if (w_final) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_xfer) begin
        r_idx  <= w_idx_nxt;
        r_data <= fmt_word(r_buf, w_idx_nxt);
        r_last <= (w_idx_nxt == '0);
      end
      if (en_i && !w_capture)
        r_ovr <= 1'b1;
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_last  = r_last;
  assign busy    = r_busy;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_sha_digest_tx.sv
// Bench for sha_digest_tx: directed scenarios then random traffic against a word-queue model.
module tb_sha_digest_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         en_i;
  logic [255:0] H_i;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         busy;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  logic        exp_ovr;

  always #5 clk = ~clk;

  sha_digest_tx dut (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en_i),
    .H_i     (H_i),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy),
    .overrun (overrun)
  );

  function automatic logic [31:0] emit(input logic [31:0] w);
`ifdef SHA_DIGEST_TX_BSWAP_EN
    return {<<8{w}};
`else
    return w;
`endif
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: pending words form a queue; a stream is valid while words remain.
  task automatic check_outputs();
    logic ev;
    ev = (q.size() > 0);
    chk1("m_valid", m_valid, ev);
    chk1("busy", busy, ev);
    chk1("overrun", overrun, exp_ovr);
    if (ev) begin
      chkw("m_data", m_data, q[0]);
      chk1("m_last", m_last, q.size() == 1);
    end
  endtask

  task automatic step(input logic en, input logic [255:0] h, input logic rdy, input logic rst);
    check_outputs();
    reset   = rst;
    en_i    = en;
    H_i     = h;
    m_ready = rdy;
    if (rst) begin
      q.delete();
      exp_ovr = 1'b0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (en) begin
        if (q.size() == 0)
          for (int k = 7; k >= 0; k--) q.push_back(emit(h[k*32 +: 32]));
        else
          exp_ovr = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_digest();
    logic [255:0] h;
    for (int k = 0; k < 8; k++) h[k*32 +: 32] = $urandom;
    return h;
  endfunction

  logic [255:0] dig_a;
  logic [255:0] dig_f;
  logic [255:0] dig_b;
  logic [255:0] dig_s;

  initial begin
    for (int k = 0; k < 8; k++) dig_a[k*32 +: 32] = 32'h11111111 * k;
    dig_f   = '1;
    dig_b   = rand_digest();
    dig_s   = '0;
    dig_s[7*32 +: 32] = 32'h01234567;
    exp_ovr = 1'b0;
    reset   = 1'b1;
    en_i    = 1'b0;
    H_i     = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);

    check_outputs();
    chkw("reset_m_data", m_data, 32'h0);
    chk1("reset_m_last", m_last, 1'b0);

    // Basic streaming with ready held high.
    step(1'b1, dig_a, 1'b1, 1'b0);
`ifndef SHA_DIGEST_TX_BSWAP_EN
    chkw("basic_first", m_data, 32'h77777777);
`endif
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure with ready pattern 1,0,0,1,...
    step(1'b1, dig_a, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, '0, (i % 3) == 0, 1'b0);

    // Back-to-back: second strobe on the final handshake.
    step(1'b1, dig_a, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, dig_b, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Overrun: all-ones digest strobed at the third word.
    step(1'b1, dig_a, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, dig_f, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-transfer after four words, then restart.
    step(1'b1, dig_b, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, dig_a, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Held strobe: captures once, then flags overrun.
    step(1'b1, dig_b, 1'b1, 1'b0);
    step(1'b1, dig_b, 1'b1, 1'b0);
    step(1'b1, dig_b, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

`ifdef SHA_DIGEST_TX_BSWAP_EN
    step(1'b1, dig_s, 1'b1, 1'b0);
    chkw("bswap_first", m_data, 32'h67452301);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) == 0, rand_digest(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 149) == 0);
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
